addsub_ovf_unit: RTL

Parametrised, registered integer add/subtract unit with signed overflow detection, carry/borrow output and MIPS-style trapping versus non-trapping modes. It sits beside the main ALU in the EX stage. It takes operands over a valid/ready handshake and returns one registered result per accepted operation. It also keeps a sticky overflow flag and a saturating overflow event counter for debug and status.

---
 rtl/addsub_ovf_unit_pkg.sv | 27 ++
 rtl/addsub_ovf_unit_core.sv | 35 +++
 rtl/addsub_ovf_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/addsub_ovf_unit_pkg.sv
// Shared op encoding and signed-overflow helpers for the add/subtract unit and the main ALU.
package addsub_ovf_unit_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ADDU = 2'd2,
        OP_SUBU = 2'd3
    } op_e;

    // Overflow needs only the three MSBs; subtraction flips the operand-sign condition.
    function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        logic same_sign;
        same_sign = (a_msb == b_msb);
        return (is_sub ? ~same_sign : same_sign) & (r_msb != a_msb);
    endfunction

    function automatic logic op_is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SUBU);
    endfunction

    function automatic logic op_is_trapping(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/addsub_ovf_unit_core.sv
// Combinational add/subtract datapath producing {carry, result} and signed overflow.
// Optional ADDSUB_SATURATE_EN clamps trapping ops on overflow instead of wrapping.
module addsub_core
    import addsub_ovf_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtraction reuses the adder as A + ~B + 1, so carry=1 means no borrow.
    always_comb begin
        sub      = op_is_sub(op_e'(op));
        b_eff    = sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        carry    = sum[WIDTH];
        overflow = signed_ovf(sub, a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
        result   = sum[WIDTH-1:0];
`ifdef ADDSUB_SATURATE_EN
        if (overflow && op_is_trapping(op_e'(op))) begin
            result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/addsub_ovf_unit.sv
// Registered add/subtract unit with valid/ready handshake, trap output, sticky flag
// and saturating overflow counter. Build option: ADDSUB_SATURATE_EN (see addsub_core).
module addsub_ovf_unit
    import addsub_ovf_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             trap,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count
);

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_ovf;
    logic             core_trap;
    logic             accept;
    logic             trap_q;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_ovf)
    );

    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign core_trap = core_ovf & op_is_trapping(op_e'(op));
    assign trap      = trap_q & out_valid;

    // Data registers only load on acceptance, so they hold under backpressure and after draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            trap_q   <= 1'b0;
        end else if (accept) begin
            result   <= core_result;
            carry    <= core_carry;
            overflow <= core_ovf;
            trap_q   <= core_trap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A trapping overflow beats a simultaneous clear, restarting the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (accept && core_trap) begin
            sticky_ovf <= 1'b1;
            if (clr_sticky) begin
                ovf_count <= CNT_W'(1);
            end else if (ovf_count != {CNT_W{1'b1}}) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule
